seq_serializer: RTL

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_serializer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial converter, MSB first, one bit per clock.
// Feeds a downstream sequence detector; idle gaps are presented as zeros.
// Back-to-back words stream with no bubble because In_ready also asserts
// during the final bit of a word.
//
// Optional feature: define SEQ_SERIALIZER_PARITY_EN to append one even-parity
// bit (XOR of the word) after the LSB, making each word DATA_W+1 cycles long.
// Without the macro there is no parity state and no parity logic.
module seq_serializer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] In_data,
    input  logic              In_valid,
    output logic              In_ready,
    output logic              Out_bit,
    output logic              Out_valid,
    output logic              Busy,
    output logic [7:0]        Word_count
);

    // Bit counter holds DATA_W after a load and counts down to 1 on the LSB.
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    // State
    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_word_cnt;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic              r_parity;
`endif

    // Combinational
    logic              w_accept;
    logic              w_lsb;
    logic              w_last;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // LSB of the current word is on Out_bit this cycle.
    assign w_lsb = (r_state == ST_SHIFT) && (r_cnt == CNT_ONE);

    // Final cycle of a word: the LSB, or the parity bit when parity is enabled.
`ifdef SEQ_SERIALIZER_PARITY_EN
    assign w_last = (r_state == ST_PAR);
`else
    assign w_last = w_lsb;
`endif

    // Ready when idle or on the final cycle so the next word follows without a gap.
    assign In_ready = (r_state == ST_IDLE) || w_last;
    assign w_accept = In_valid && In_ready;

    // Next-state, shift register and bit counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_SHIFT: begin
                w_shift_nxt = r_shift << 1;
                w_cnt_nxt   = r_cnt - CNT_ONE;
                if (w_lsb) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                    w_state_nxt = ST_PAR;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef SEQ_SERIALIZER_PARITY_EN
            ST_PAR: begin
                w_state_nxt = ST_IDLE;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A load overrides everything, including the final-cycle return to idle.
        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_shift_nxt = In_data;
            w_cnt_nxt   = CNT_LOAD;
        end
    end

    // Datapath and FSM registers; reset discards any partially shifted word.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef SEQ_SERIALIZER_PARITY_EN
    // Even parity of the word, captured at accept and sent after the LSB.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^In_data;
        end
    end
`endif

    // Completed-word counter; increments on the edge ending a word, wraps at 8'hFF.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_word_cnt <= 8'h00;
        end else if (w_last) begin
            r_word_cnt <= r_word_cnt + 8'h01;
        end
    end

    // Serial output; forced to zero whenever no data bit is presented.
    always_comb begin
        Out_valid = 1'b0;
        Out_bit   = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                Out_valid = 1'b1;
                Out_bit   = r_shift[DATA_W-1];
            end
`ifdef SEQ_SERIALIZER_PARITY_EN
            ST_PAR: begin
                Out_valid = 1'b1;
                Out_bit   = r_parity;
            end
`endif
            default: begin
                Out_valid = 1'b0;
                Out_bit   = 1'b0;
            end
        endcase
    end

    assign Busy       = Out_valid;
    assign Word_count = r_word_cnt;

endmodule
